// File: rtl/clock_time_counter_pkg.sv
// clock_time_counter_pkg: adjust-mode encodings, BCD limits and the wrapping BCD field increment shared with the display path
package clock_time_counter_pkg;

    typedef enum logic [1:0] {
        ADJ_RUN  = 2'd0,
        ADJ_SEC  = 2'd1,
        ADJ_MIN  = 2'd2,
        ADJ_HOUR = 2'd3
    } adj_e;

    localparam logic [3:0] BCD_SEC_H_MAX  = 4'd5;
    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_HOUR_H_MAX = 4'd2;
    localparam logic [3:0] BCD_HOUR_L_MAX = 4'd3;
    localparam logic [3:0] BCD_BLANK      = 4'hF;

    localparam logic [7:0] SEC_LIMIT  = {BCD_SEC_H_MAX, BCD_DIGIT_MAX};
    localparam logic [7:0] MIN_LIMIT  = {BCD_SEC_H_MAX, BCD_DIGIT_MAX};
    localparam logic [7:0] HOUR_LIMIT = {BCD_HOUR_H_MAX, BCD_HOUR_L_MAX};

    // Two-digit BCD +1 that wraps to 00 after reaching limit; the caller derives the carry from v == limit
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        if (v == limit)
            return 8'h00;
        if (v[3:0] == BCD_DIGIT_MAX)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/clock_time_counter_key_debounce.sv
// clock_time_counter_key_debounce: 2-FF synchroniser plus stable-time filter for one raw active-low key; emits one pulse per accepted press (built only with KEY_DEBOUNCE_EN)
`ifdef KEY_DEBOUNCE_EN
module clock_time_counter_key_debounce #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the asynchronous key into the clock domain; idle level is released (high)
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], i_key_n};
    end

    // Accept a new level only after it has differed from the current one for STABLE_CYCLES cycles; pulse on accepted 1->0
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            level   <= 1'b1;
            cnt     <= '0;
            o_press <= 1'b0;
        end else begin
            o_press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level   <= sync[1];
                cnt     <= '0;
                o_press <= !sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/clock_time_counter.sv
// clock_time_counter: 24-h BCD time counter with half-second prescaler and key-driven adjust; define KEY_DEBOUNCE_EN for raw active-low debounced keys
module clock_time_counter
    import clock_time_counter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_key_mode,
    input  logic       i_key_inc,
    output logic [3:0] o_hour_h,
    output logic [3:0] o_hour_l,
    output logic [3:0] o_minut_h,
    output logic [3:0] o_minut_l,
    output logic [3:0] o_second_h,
    output logic [3:0] o_second_l,
    output logic [1:0] o_adjust_cnt,
    output logic       o_0_5s_clk,
    output logic       o_second_tick
);

    localparam int HALF_CYCLES = CLK_FREQ_HZ / 2;
    localparam int PS_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(HALF_CYCLES - 1);

    if (CLK_FREQ_HZ < 2 || CLK_FREQ_HZ % 2 != 0 || DEBOUNCE_MS < 0) begin : g_bad_params
        $error("clock_time_counter: CLK_FREQ_HZ must be even and >= 2, DEBOUNCE_MS must be >= 0");
    end

    logic mode_press;
    logic inc_press;

`ifdef KEY_DEBOUNCE_EN
    localparam longint DEB_RAW = longint'(DEBOUNCE_MS) * CLK_FREQ_HZ / 1000;
    localparam int DEB_CYCLES = (DEB_RAW < 1) ? 1 : int'(DEB_RAW);

    clock_time_counter_key_debounce #(.STABLE_CYCLES(DEB_CYCLES)) u_deb_mode (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_key_n   (i_key_mode),
        .o_press   (mode_press)
    );

    clock_time_counter_key_debounce #(.STABLE_CYCLES(DEB_CYCLES)) u_deb_inc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_key_n   (i_key_inc),
        .o_press   (inc_press)
    );
`else
    assign mode_press = i_key_mode;
    assign inc_press  = i_key_inc;
`endif

    adj_e            adj;
    logic [PS_W-1:0] ps_cnt;
    logic            blink;
    logic            tick_q;
    logic [7:0]      sec;
    logic [7:0]      min;
    logic [7:0]      hour;
    logic            ps_tc;
    logic            run_tick;
    logic            leave_adjust;

    assign ps_tc        = ps_cnt == PS_LAST;
    assign run_tick     = ps_tc && blink && adj == ADJ_RUN;
    assign leave_adjust = mode_press && adj == ADJ_HOUR;

    // Half-second prescaler and blink clock; leaving adjust restarts them so the first second is a full one
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ps_cnt <= '0;
            blink  <= 1'b0;
        end else if (leave_adjust) begin
            ps_cnt <= '0;
            blink  <= 1'b0;
        end else if (ps_tc) begin
            ps_cnt <= '0;
            blink  <= !blink;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // Adjust selector: each mode press steps run -> sec -> min -> hour -> run
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            adj <= ADJ_RUN;
        end else if (mode_press) begin
            case (adj)
                ADJ_RUN:  adj <= ADJ_SEC;
                ADJ_SEC:  adj <= ADJ_MIN;
                ADJ_MIN:  adj <= ADJ_HOUR;
                default:  adj <= ADJ_RUN;
            endcase
        end
    end

    // Time registers: carry chain on run ticks, single-field wrap on inc presses in adjust (mode press drops inc)
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sec    <= 8'h00;
            min    <= 8'h00;
            hour   <= 8'h00;
            tick_q <= 1'b0;
        end else begin
            tick_q <= run_tick;
            if (run_tick) begin
                sec <= bcd_inc(sec, SEC_LIMIT);
                if (sec == SEC_LIMIT) begin
                    min <= bcd_inc(min, MIN_LIMIT);
                    if (min == MIN_LIMIT)
                        hour <= bcd_inc(hour, HOUR_LIMIT);
                end
            end else if (inc_press && !mode_press) begin
                case (adj)
                    ADJ_SEC:  sec  <= bcd_inc(sec, SEC_LIMIT);
                    ADJ_MIN:  min  <= bcd_inc(min, MIN_LIMIT);
                    ADJ_HOUR: hour <= bcd_inc(hour, HOUR_LIMIT);
                    default:  ;
                endcase
            end
        end
    end

    assign o_hour_h      = hour[7:4];
    assign o_hour_l      = hour[3:0];
    assign o_minut_h     = min[7:4];
    assign o_minut_l     = min[3:0];
    assign o_second_h    = sec[7:4];
    assign o_second_l    = sec[3:0];
    assign o_adjust_cnt  = adj;
    assign o_0_5s_clk    = blink;
    assign o_second_tick = tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed self-checking bench at CLK_FREQ_HZ=4 (2 cycles per half-second)
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic [1:0] adj;
    logic       blink;
    logic       tick;
    int         n_cmp = 0;
    int         n_err = 0;
    int         ticks = 0;

    always #5 clk = ~clk;

    clock_time_counter #(.CLK_FREQ_HZ(4), .DEBOUNCE_MS(1)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_key_mode    (key_mode),
        .i_key_inc     (key_inc),
        .o_hour_h      (hh),
        .o_hour_l      (hl),
        .o_minut_h     (mh),
        .o_minut_l     (ml),
        .o_second_h    (sh),
        .o_second_l    (sl),
        .o_adjust_cnt  (adj),
        .o_0_5s_clk    (blink),
        .o_second_tick (tick)
    );

    function automatic logic [31:0] now();
        return {8'h00, hh, hl, mh, ml, sh, sl};
    endfunction

    function automatic logic bcd_ok();
        return sh <= 4'd5 && sl <= 4'd9 && mh <= 4'd5 && ml <= 4'd9 &&
               hh <= 4'd2 && hl <= ((hh == 4'd2) ? 4'd3 : 4'd9);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input int n);
        key_mode = m;
        key_inc  = i;
        step(n);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    initial begin
        // reset state
        step(3);
        chk("reset_time", now(), 32'h000000);
        chk("reset_adj", 32'(adj), 0);
        chk("reset_blink", 32'(blink), 0);
        chk("reset_tick", 32'(tick), 0);
        rst_n = 1'b1;

        // free run: 240 cycles -> 00:01:00, 60 ticks, blink toggles every 2 cycles
        for (int k = 1; k <= 240; k++) begin
            step(1);
            chk("run_blink", 32'(blink), 32'((k >> 1) & 1));
            chk("run_tick", 32'(tick), 32'(k % 4 == 0));
            ticks += int'(tick);
        end
        chk("run_time", now(), 32'h000100);
        chk("run_tick_count", 32'(ticks), 60);

        // preload 23:59:58 through adjust, then leave adjust
        press(1, 0, 1);
        chk("enter_adj", 32'(adj), 1);
        press(0, 1, 58);
        press(1, 0, 1);
        press(0, 1, 58);
        press(1, 0, 1);
        press(0, 1, 23);
        chk("preload_adj", 32'(adj), 3);
        chk("preload_time", now(), 32'h235958);
        press(1, 0, 1);
        chk("leave_adj", 32'(adj), 0);
        chk("leave_blink", 32'(blink), 0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("wrap_bcd_range", 32'(bcd_ok()), 1);
            chk("wrap_tick", 32'(tick), 32'(k % 4 == 0));
            if (k == 4) chk("wrap_235959", now(), 32'h235959);
            if (k == 8) chk("wrap_000000", now(), 32'h000000);
        end

        // adjust seconds: inc x61 wraps through 00 to 01; time frozen
        press(1, 0, 1);
        press(0, 1, 61);
        chk("sec_adj", 32'(adj), 1);
        chk("sec_wrap_time", now(), 32'h000001);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("frozen_tick", 32'(tick), 0);
        end
        chk("frozen_time", now(), 32'h000001);

        // mode x3 back to run, mode x3 again to hour adjust, inc x25 -> hour 01
        press(1, 0, 3);
        chk("back_to_run", 32'(adj), 0);
        press(1, 0, 3);
        chk("hour_adj", 32'(adj), 3);
        press(0, 1, 25);
        chk("hour_wrap_time", now(), 32'h010001);
        press(1, 0, 1);
        chk("run_again", 32'(adj), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("first_tick_4", 32'(tick), 32'(k == 4));
        end
        chk("after_first_tick", now(), 32'h010002);

        // mode and inc together in sec adjust: mode wins, seconds unchanged
        press(1, 0, 1);
        press(1, 1, 1);
        chk("both_keys_adj", 32'(adj), 2);
        chk("both_keys_time", now(), 32'h010002);

        // set 12:34:56 in minute adjust, then async reset between clock edges
        press(1, 0, 1);
        press(0, 1, 11);
        press(1, 0, 1);
        press(1, 0, 1);
        press(0, 1, 54);
        press(1, 0, 1);
        press(0, 1, 34);
        chk("pre_reset_adj", 32'(adj), 2);
        chk("pre_reset_time", now(), 32'h123456);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_time", now(), 32'h000000);
        chk("async_reset_adj", 32'(adj), 0);
        chk("async_reset_blink", 32'(blink), 0);
        chk("async_reset_tick", 32'(tick), 0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("post_reset_tick", 32'(tick), 32'(k == 4));
        end
        chk("post_reset_time", now(), 32'h000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
